// File: rtl/cp0_exc_unit.sv
// CP0 exception sequencer: decodes and masks a cause word, saves EPC/Cause/Status,
// redirects the PC to the handler, and serves eret, mtc0 and mfc0.
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter logic [31:0] STATUS_RESET = 32'h0000_000F,
    parameter int unsigned SHIFT        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [31:0] cause_in,
    input  logic [31:0] pc_in,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        exc_ack,
    output logic        exc_taken,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SAVE = 3'd1,
        S_VECT = 3'd2,
        S_NACK = 3'd3,
        S_ERET = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] lat_cause, lat_pc;
    logic        enable_bit, take;

    // An exception is taken only if globally enabled and its own enable bit is set.
    always_comb begin
        enable_bit = 1'b0;
        case (cause_in[6:2])
            5'd8:    enable_bit = status[1];
            5'd9:    enable_bit = status[2];
            5'd13:   enable_bit = status[3];
            default: enable_bit = 1'b0;
        endcase
        take = status[0] & enable_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (exc_req)   state_nxt = take ? S_SAVE : S_NACK;
                else if (eret) state_nxt = S_ERET;
            end
            S_SAVE:  state_nxt = S_VECT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        redirect    = (state == S_VECT) || (state == S_ERET);
        exc_ack     = (state == S_VECT) || (state == S_NACK);
        exc_taken   = (state == S_VECT);
        redirect_pc = 32'h0;
        if (state == S_VECT)      redirect_pc = EXC_VECTOR;
        else if (state == S_ERET) redirect_pc = epc;
        dbg_state   = state;
    end

    // Priority exc_req > eret > mtc0 holds only in IDLE; everything is ignored while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status    <= STATUS_RESET;
            cause     <= 32'h0;
            epc       <= 32'h0;
            lat_cause <= 32'h0;
            lat_pc    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_req) begin
                        lat_cause <= cause_in;
                        lat_pc    <= pc_in;
                    end else if (eret) begin
                        status <= status >> SHIFT;
                    end else if (mtc0_we) begin
                        case (cp0_addr)
                            5'd12:   status <= wdata;
                            5'd13:   cause  <= wdata;
                            5'd14:   epc    <= wdata;
                            default: ;
                        endcase
                    end
                end
                S_SAVE: begin
                    epc    <= lat_pc;
                    cause  <= lat_cause;
                    status <= status << SHIFT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (cp0_addr)
            5'd12:   rdata = status;
            5'd13:   rdata = cause;
            5'd14:   rdata = epc;
            default: rdata = 32'h0;
        endcase
    end

endmodule
